// File: rtl/cpu_bus_ctrl.sv
// cpu_bus_ctrl: region decode, per-region read wait states and a posted-write FIFO
// sitting between the cpu6502 core and memory.
module cpu_bus_ctrl #(
    parameter int         RAM_WAIT    = 0,
    parameter int         IO_WAIT     = 2,
    parameter int         ROM_WAIT    = 1,
    parameter logic [7:0] IO_PAGE_LO  = 8'hD0,
    parameter logic [7:0] IO_PAGE_HI  = 8'hDF,
    parameter logic [7:0] ROM_PAGE_LO = 8'hE0,
    parameter int         WBUF_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] cpu_address,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_data_o,
    output logic [7:0]  cpu_data_i,
    output logic        cpu_ready,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_rd,
    output logic [1:0]  mem_region,
    input  logic [7:0]  mem_rdata,
    input  logic        io_wait,
    output logic        wbuf_ovf
);
    localparam int AW = $clog2(WBUF_DEPTH);
    localparam logic [1:0] RG_RAM = 2'd0, RG_IO = 2'd1, RG_ROM = 2'd2;
    localparam logic [0:0] IDLE = 1'b0, RD_WAIT = 1'b1;

    function automatic logic [1:0] decode(input logic [15:0] a);
        return (a[15:8] >= IO_PAGE_LO && a[15:8] <= IO_PAGE_HI) ? RG_IO :
               (a[15:8] >= ROM_PAGE_LO) ? RG_ROM : RG_RAM;
    endfunction

    function automatic logic [2:0] wait_of(input logic [1:0] r);
        return r == RG_IO ? 3'(IO_WAIT) : r == RG_ROM ? 3'(ROM_WAIT) : 3'(RAM_WAIT);
    endfunction

    logic [25:0]   fifo [WBUF_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic [0:0]    state;
    logic [2:0]    cnt, dcnt;
    logic [15:0]   rd_addr;
    logic [1:0]    rd_region, cpu_region;
    logic [2:0]    cpu_w, head_w;
    logic [25:0]   head;
    logic          empty, full, drain, direct, push, pop, rd_done;

    assign cpu_region = decode(cpu_address);
    assign cpu_w      = wait_of(cpu_region);
    assign head       = fifo[rd_ptr];
    assign head_w     = wait_of(head[1:0]);
    assign empty      = count == '0;
    assign full       = count == (AW+1)'(WBUF_DEPTH);
    // Draining pauses while a read owns the bus in RD_WAIT
    assign drain      = !empty && state == IDLE;
    assign pop        = drain && dcnt == head_w && !(head[1:0] == RG_IO && io_wait);
    assign direct     = cpu_write && empty && state == IDLE && cpu_w == 3'd0;
    assign push       = cpu_write && !direct && (!full || pop);
    assign rd_done    = state == RD_WAIT && cnt == 3'd1 && !(rd_region == RG_IO && io_wait);

    assign mem_we     = reset && (drain || direct);
    assign mem_rd     = reset && (state == RD_WAIT || (state == IDLE && !cpu_write && empty));
    assign mem_addr   = drain ? head[25:10] : state == RD_WAIT ? rd_addr : cpu_address;
    assign mem_wdata  = drain ? head[9:2] : cpu_data_o;
    assign mem_region = drain ? head[1:0] : state == RD_WAIT ? rd_region : cpu_region;
    assign cpu_ready  = !reset || cpu_write || (state == IDLE ? empty && cpu_w == 3'd0 : rd_done);
    assign cpu_data_i = (cpu_ready && mem_rd && !cpu_write) ? mem_rdata : 8'h00;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            state     <= IDLE;
            cnt       <= 3'd0;
            dcnt      <= 3'd0;
            wbuf_ovf  <= 1'b0;
            rd_addr   <= 16'h0000;
            rd_region <= RG_RAM;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
            if (cpu_write && !direct && full && !pop) wbuf_ovf <= 1'b1;
            // Head cycle counter saturates on the final cycle so IO extension simply repeats it
            dcnt <= (pop || empty) ? 3'd0 : (!drain || dcnt == head_w) ? dcnt : dcnt + 3'd1;
            if (state == IDLE) begin
                if (!cpu_write && empty && cpu_w != 3'd0) begin
                    state     <= RD_WAIT;
                    cnt       <= cpu_w;
                    rd_addr   <= cpu_address;
                    rd_region <= cpu_region;
                end
            end else if (rd_done) begin
                state <= IDLE;
                cnt   <= 3'd0;
            end else if (cnt != 3'd1) begin
                cnt <= cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= {cpu_address, cpu_data_o, cpu_region};
    end
endmodule

// File: doc/cpu_bus_ctrl.md
Name: cpu_bus_ctrl

Overview:
- Memory-side bus controller directly downstream of the cpu6502 core. Consumes the core's address/write/data_o and produces its ready and data_i.
- Decodes each access into RAM, IO or ROM and inserts per-region wait states by holding ready low on reads.
- The core ignores ready on write cycles, so writes cannot be stalled. They are absorbed by a small posted-write FIFO that drains to memory in the background.

Parameters:
- RAM_WAIT, 0, wait cycles for RAM accesses (0..7)
- IO_WAIT, 2, wait cycles for IO accesses (0..7), extendable by io_wait
- ROM_WAIT, 1, wait cycles for ROM accesses (0..7)
- IO_PAGE_LO, 8'hD0, first IO page (address[15:8])
- IO_PAGE_HI, 8'hDF, last IO page
- ROM_PAGE_LO, 8'hE0, pages >= this are ROM; all other pages are RAM
- WBUF_DEPTH, 4, posted-write FIFO entries (power of 2, >= 4 so BRK/IRQ triple push fits)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- cpu_address  in  16  core address bus
- cpu_write  in  1  core write strobe
- cpu_data_o  in  8  core write data
- cpu_data_i  out  8  read data to core
- cpu_ready  out  1  ready to core
- mem_addr  out  16  memory address
- mem_wdata  out  8  memory write data
- mem_we  out  1  memory write enable
- mem_rd  out  1  memory read strobe
- mem_region  out  2  0=RAM, 1=IO, 2=ROM, 3=unused
- mem_rdata  in  8  memory read data (combinational/asynchronous read)
- io_wait  in  1  IO device extend request
- wbuf_ovf  out  1  sticky: write dropped because the FIFO was full

Behaviour:
- Region decode (combinational): IO if IO_PAGE_LO <= page <= IO_PAGE_HI; else ROM if page >= ROM_PAGE_LO; else RAM. IO has priority over ROM.
- The wait count W comes from the region parameter.
- Reset (reset=0, async):
  - FIFO empty, state IDLE, counter 0, wbuf_ovf=0.
  - Outputs: cpu_ready=1, mem_we=0, mem_rd=0.
  - Pending buffered writes are discarded, including on a mid-operation reset.
- FIFO entries hold {addr[15:0], data[7:0], region[1:0]}.
- FIFO count rules:
  - Push and pop in the same cycle leave the count unchanged.
  - A push when full with a simultaneous pop is accepted.
  - A push when full with no pop is dropped and sets wbuf_ovf until reset.
- Drain (FIFO non-empty):
  - mem_addr/mem_wdata/mem_region come from the head entry; mem_we=1, mem_rd=0.
  - The head is held W+1 cycles. For IO, the final cycle repeats while io_wait=1.
  - The entry pops at the end of its final cycle. The next entry starts the following cycle with no gap.
- CPU write cycle (cpu_write=1):
  - cpu_ready=1 always.
  - Direct path: if the FIFO is empty, state is IDLE and W=0, drive memory directly this cycle (mem_we=1, mem_addr=cpu_address) with no push.
  - Otherwise push {cpu_address, cpu_data_o, region} at the clock edge.
- CPU read cycle (cpu_write=0), state IDLE:
  - FIFO non-empty: cpu_ready=0; remain IDLE until empty (read-after-write ordering guaranteed).
  - FIFO empty and W=0: mem_rd=1, mem_addr=cpu_address, cpu_data_i=mem_rdata, cpu_ready=1.
  - FIFO empty and W>0: latch address and region, load counter=W, cpu_ready=0, enter RD_WAIT.
- RD_WAIT:
  - mem_rd=1 with the latched address/region.
  - Counter decrements each cycle.
  - In the cycle counter==1 (and io_wait=0 for IO): cpu_ready=1, cpu_data_i=mem_rdata, return to IDLE.
  - If io_wait=1 at that point, the counter holds at 1 and cpu_ready stays 0.
  - Total read latency is W+1 cycles from the first read cycle.
- cpu_data_i is 8'h00 whenever cpu_ready=0 or a write is in progress.
- The address latch makes RD_WAIT immune to cpu_address changes.
- The counter is 3 bits and never underflows.

Test Plan:
- RAM read at 16'h0200, W=0, mem_rdata=8'h5A: cpu_ready=1 in the same cycle, cpu_data_i=8'h5A, mem_rd=1.
- ROM read at 16'hFFFC (ROM_WAIT=1): cpu_ready=0 for 1 cycle, then 1 with data; IO read at 16'hD012 with io_wait high 3 extra cycles: ready asserts at cycle 2+3+1=6.
- BRK-style triple push: writes to 16'hD100,16'hD101,16'hD102 (IO, W=2) on consecutive cycles: cpu_ready stays 1, count reaches 3, mem_we pulses in order for 3 cycles each, addresses/data match, wbuf_ovf=0.
- Read immediately after a buffered IO write: cpu_ready=0 until the FIFO drains (3 cycles), then read completes; no stale data returned.
- Six consecutive IO writes with no pop opportunity: fifth/sixth dropped when full, wbuf_ovf=1 and stays 1; RAM write with empty FIFO goes direct (mem_we same cycle, count stays 0).
- Assert reset low mid-drain with 2 entries pending: mem_we=0 immediately, cpu_ready=1, FIFO empty after release, wbuf_ovf cleared.
